// File: rtl/seq_pattern_gen_1001_1110.sv
// -----------------------------------------------------------------------------
// seq_pattern_gen_1001_1110
//
// Serial pattern transmitter feeding the 1001/1110 Mealy sequence detector.
// On an accepted start it shifts out 1001 (sel=0) or 1110 (sel=1), MSB first,
// one bit per clock, repeated repeat_n times (0 counts as 1). GAP_CYCLES idle
// cycles separate consecutive patterns. On bit0 of each pattern last_bit and
// exp_code flag the code the detector should report in that same cycle.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      request pulse, accepted only while busy=0
//   sel        pattern select (0: 1001, 1: 1110), sampled on accepted start
//   repeat_n   number of patterns to send (0 -> 1), sampled on accepted start
//   abort      synchronous cancel of a run in progress
//   out        serial data bit, 0 whenever out_valid=0
//   out_valid  out carries a pattern bit this cycle
//   busy       run in progress (SEND or GAP)
//   last_bit   high with bit0 of each pattern
//   exp_code   expected detector code while last_bit=1, else 0000
//   done       one-cycle pulse after the final bit of the final pattern
//   pat_cnt    patterns fully sent in the current/last run (saturating)
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module seq_pattern_gen_1001_1110 #(
   parameter int unsigned CNT_W      = 4,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sel,
   input  logic [CNT_W-1:0] repeat_n,
   input  logic             abort,
   output logic             out,
   output logic             out_valid,
   output logic             busy,
   output logic             last_bit,
   output logic [3:0]       exp_code,
   output logic             done,
   output logic [CNT_W-1:0] pat_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [3:0]  PAT_1001 = 4'b1001;
   localparam logic [3:0]  PAT_1110 = 4'b1110;
   // Gap counter is loaded with GAP_CYCLES-1 and counts down to zero.
   localparam int unsigned GAP_M1   = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   localparam logic [3:0]  GAP_LOAD = GAP_M1[3:0];

   state_t           state;
   logic             sel_q;     // latched pattern select
   logic [CNT_W-1:0] rem_q;     // patterns still to start after the current one
   logic [1:0]       idx_q;     // index of the bit currently on out
   logic [3:0]       gap_q;     // remaining gap cycles minus one

   logic [3:0]       pat_q;
   logic [1:0]       idx_nxt;
   logic [CNT_W-1:0] rep_eff;
   logic [CNT_W-1:0] cnt_inc;

   always_comb begin
      pat_q   = sel_q ? PAT_1110 : PAT_1001;
      idx_nxt = idx_q - 2'd1;
      rep_eff = (repeat_n == '0) ? CNT_W'(1) : repeat_n;
      cnt_inc = (pat_cnt == '1) ? pat_cnt : pat_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sel_q     <= 1'b0;
         rem_q     <= '0;
         idx_q     <= '0;
         gap_q     <= '0;
         out       <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         last_bit  <= 1'b0;
         exp_code  <= '0;
         done      <= 1'b0;
         pat_cnt   <= '0;
      end else begin
         unique case (state)
            // DONE behaves like IDLE for start acceptance since busy is low.
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  sel_q     <= sel;
                  rem_q     <= rep_eff - CNT_W'(1);
                  pat_cnt   <= '0;
                  idx_q     <= 2'd3;
                  // Both patterns begin with a 1.
                  out       <= 1'b1;
                  out_valid <= 1'b1;
                  busy      <= 1'b1;
                  last_bit  <= 1'b0;
                  exp_code  <= '0;
                  state     <= SEND;
               end else begin
                  state     <= IDLE;
               end
            end

            SEND: begin
               if (abort) begin
                  out       <= 1'b0;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  last_bit  <= 1'b0;
                  exp_code  <= '0;
                  state     <= IDLE;
               end else if (idx_q != 2'd0) begin
                  idx_q <= idx_nxt;
                  out   <= pat_q[idx_nxt];
                  if (idx_nxt == 2'd0) begin
                     last_bit <= 1'b1;
                     exp_code <= pat_q;
                     pat_cnt  <= cnt_inc;
                  end
               end else begin
                  last_bit <= 1'b0;
                  exp_code <= '0;
                  if (rem_q != '0) begin
                     rem_q <= rem_q - CNT_W'(1);
                     if (GAP_CYCLES == 0) begin
                        idx_q <= 2'd3;
                        out   <= pat_q[3];
                     end else begin
                        gap_q     <= GAP_LOAD;
                        out       <= 1'b0;
                        out_valid <= 1'b0;
                        state     <= GAP;
                     end
                  end else begin
                     out       <= 1'b0;
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     state     <= DONE;
                  end
               end
            end

            GAP: begin
               if (abort) begin
                  out       <= 1'b0;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  last_bit  <= 1'b0;
                  exp_code  <= '0;
                  state     <= IDLE;
               end else if (gap_q == 4'd0) begin
                  idx_q     <= 2'd3;
                  out       <= pat_q[3];
                  out_valid <= 1'b1;
                  state     <= SEND;
               end else begin
                  gap_q <= gap_q - 4'd1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_pattern_gen_1001_1110.sv
module tb_seq_pattern_gen_1001_1110;

   logic       clk = 1'b0;
   logic       rst_n, start_a, start_b, sel, abort;
   logic [3:0] repeat_n;

   logic       a_out, a_out_valid, a_busy, a_last_bit, a_done;
   logic [3:0] a_exp_code, a_pat_cnt;
   logic       b_out, b_out_valid, b_busy, b_last_bit, b_done;
   logic [3:0] b_exp_code, b_pat_cnt;

   int checks   = 0;
   int failures = 0;

   logic [8:0] exp_q[$];

   always #5 clk = ~clk;

   seq_pattern_gen_1001_1110 #(.CNT_W(4), .GAP_CYCLES(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .sel(sel), .repeat_n(repeat_n),
      .abort(abort), .out(a_out), .out_valid(a_out_valid), .busy(a_busy),
      .last_bit(a_last_bit), .exp_code(a_exp_code), .done(a_done), .pat_cnt(a_pat_cnt)
   );

   seq_pattern_gen_1001_1110 #(.CNT_W(4), .GAP_CYCLES(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .sel(sel), .repeat_n(repeat_n),
      .abort(abort), .out(b_out), .out_valid(b_out_valid), .busy(b_busy),
      .last_bit(b_last_bit), .exp_code(b_exp_code), .done(b_done), .pat_cnt(b_pat_cnt)
   );

   // {busy, out_valid, out, last_bit, exp_code, done}
   function automatic logic [8:0] v(input logic b, input logic ov, input logic o,
                                    input logic lb, input logic [3:0] ec, input logic d);
      return {b, ov, o, lb, ec, d};
   endfunction

   function automatic logic [8:0] obs_a();
      return {a_busy, a_out_valid, a_out, a_last_bit, a_exp_code, a_done};
   endfunction

   function automatic logic [8:0] obs_b();
      return {b_busy, b_out_valid, b_out, b_last_bit, b_exp_code, b_done};
   endfunction

   function automatic void push_pat(input logic [3:0] p);
      for (int k = 0; k < 4; k++)
         exp_q.push_back(v(1'b1, 1'b1, p[3-k], k == 3, (k == 3) ? p : 4'b0000, 1'b0));
   endfunction

   function automatic void push_gap(input int n);
      for (int k = 0; k < n; k++) exp_q.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0));
   endfunction

   function automatic void push_done();
      exp_q.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1));
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; sel = 1'b0; abort = 1'b0; repeat_n = 4'd0;
      step(); step();
      checks++;
      if (obs_a() !== 9'd0 || a_pat_cnt !== 4'd0) begin
         failures++;
         $display("FAIL reset_a got=%b cnt=%0d want=%b cnt=0", obs_a(), a_pat_cnt, 9'd0);
      end
      checks++;
      if (obs_b() !== 9'd0 || b_pat_cnt !== 4'd0) begin
         failures++;
         $display("FAIL reset_b got=%b cnt=%0d want=%b cnt=0", obs_b(), b_pat_cnt, 9'd0);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single_1001();
      int c;
      exp_q.delete();
      push_pat(4'b1001); push_done();
      sel = 1'b0; repeat_n = 4'd1; start_a = 1'b1;
      step();
      start_a = 1'b0;
      c = 0;
      while (exp_q.size() > 0) begin
         logic [8:0] e;
         e = exp_q.pop_front();
         checks++;
         if (obs_a() !== e) begin
            failures++;
            $display("FAIL single_1001 cyc%0d got=%b want=%b", c, obs_a(), e);
         end
         step();
         c++;
      end
      checks++;
      if (a_pat_cnt !== 4'd1 || a_done !== 1'b0) begin
         failures++;
         $display("FAIL single_1001_end cnt=%0d done=%b want cnt=1 done=0", a_pat_cnt, a_done);
      end
   endtask

   task automatic test_repeat_gap();
      int c, busy_cnt, lb_cnt;
      exp_q.delete();
      push_pat(4'b1110); push_gap(2); push_pat(4'b1110); push_gap(2); push_pat(4'b1110); push_done();
      sel = 1'b1; repeat_n = 4'd3; start_a = 1'b1;
      step();
      start_a = 1'b0;
      c = 0; busy_cnt = 0; lb_cnt = 0;
      while (exp_q.size() > 0) begin
         logic [8:0] e;
         e = exp_q.pop_front();
         if (a_busy === 1'b1) busy_cnt++;
         if (a_last_bit === 1'b1) lb_cnt++;
         checks++;
         if (obs_a() !== e) begin
            failures++;
            $display("FAIL repeat_gap cyc%0d got=%b want=%b", c, obs_a(), e);
         end
         step();
         c++;
      end
      checks++;
      if (busy_cnt != 16 || lb_cnt != 3 || a_pat_cnt !== 4'd3) begin
         failures++;
         $display("FAIL repeat_gap_totals busy=%0d lb=%0d cnt=%0d want busy=16 lb=3 cnt=3",
                  busy_cnt, lb_cnt, a_pat_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int c;
      exp_q.delete();
      push_pat(4'b1001); push_pat(4'b1001); push_done();
      sel = 1'b0; repeat_n = 4'd2; start_b = 1'b1;
      step();
      start_b = 1'b0;
      c = 0;
      while (exp_q.size() > 0) begin
         logic [8:0] e;
         e = exp_q.pop_front();
         checks++;
         if (obs_b() !== e) begin
            failures++;
            $display("FAIL back_to_back cyc%0d got=%b want=%b", c, obs_b(), e);
         end
         step();
         c++;
      end
      checks++;
      if (b_pat_cnt !== 4'd2) begin
         failures++;
         $display("FAIL back_to_back_cnt got=%0d want=2", b_pat_cnt);
      end
   endtask

   task automatic test_busy_start();
      int c;
      exp_q.delete();
      push_pat(4'b1001); push_pat(4'b1001); push_done();
      sel = 1'b0; repeat_n = 4'd2; start_b = 1'b1;
      step();
      start_b = 1'b0;
      c = 0;
      while (exp_q.size() > 0) begin
         logic [8:0] e;
         e = exp_q.pop_front();
         checks++;
         if (obs_b() !== e) begin
            failures++;
            $display("FAIL busy_start cyc%0d got=%b want=%b", c, obs_b(), e);
         end
         if (c == 1) begin
            start_b = 1'b1; sel = 1'b1; repeat_n = 4'd5;
         end else begin
            start_b = 1'b0;
         end
         step();
         c++;
      end
      checks++;
      if (b_pat_cnt !== 4'd2) begin
         failures++;
         $display("FAIL busy_start_cnt got=%0d want=2", b_pat_cnt);
      end
      // repeat_n=0 must send exactly one pattern.
      exp_q.delete();
      push_pat(4'b1001); push_done();
      sel = 1'b0; repeat_n = 4'd0; start_b = 1'b1;
      step();
      start_b = 1'b0;
      c = 0;
      while (exp_q.size() > 0) begin
         logic [8:0] e;
         e = exp_q.pop_front();
         checks++;
         if (obs_b() !== e) begin
            failures++;
            $display("FAIL repeat_zero cyc%0d got=%b want=%b", c, obs_b(), e);
         end
         step();
         c++;
      end
      checks++;
      if (b_pat_cnt !== 4'd1) begin
         failures++;
         $display("FAIL repeat_zero_cnt got=%0d want=1", b_pat_cnt);
      end
   endtask

   task automatic test_abort();
      int c;
      sel = 1'b1; repeat_n = 4'd2; start_a = 1'b1;
      step();
      start_a = 1'b0;
      checks++;
      if (obs_a() !== v(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0)) begin
         failures++;
         $display("FAIL abort_bit1 got=%b want=%b", obs_a(), v(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0));
      end
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      checks++;
      if (obs_a() !== 9'd0 || a_pat_cnt !== 4'd0) begin
         failures++;
         $display("FAIL abort_next got=%b cnt=%0d want=%b cnt=0", obs_a(), a_pat_cnt, 9'd0);
      end
      step();
      checks++;
      if (obs_a() !== 9'd0) begin
         failures++;
         $display("FAIL abort_no_done got=%b want=%b", obs_a(), 9'd0);
      end
      exp_q.delete();
      push_pat(4'b1110); push_done();
      sel = 1'b1; repeat_n = 4'd1; start_a = 1'b1;
      step();
      start_a = 1'b0;
      c = 0;
      while (exp_q.size() > 0) begin
         logic [8:0] e;
         e = exp_q.pop_front();
         checks++;
         if (obs_a() !== e) begin
            failures++;
            $display("FAIL abort_restart cyc%0d got=%b want=%b", c, obs_a(), e);
         end
         step();
         c++;
      end
   endtask

   task automatic test_saturate();
      int lb_cnt;
      logic seen_done;
      sel = 1'b0; repeat_n = 4'd15; start_b = 1'b1;
      step();
      start_b = 1'b0;
      lb_cnt = 0; seen_done = 1'b0;
      for (int c = 0; c < 61; c++) begin
         if (b_last_bit === 1'b1) lb_cnt++;
         if (b_done === 1'b1) seen_done = (c == 60);
         step();
      end
      checks++;
      if (lb_cnt != 15 || seen_done !== 1'b1 || b_pat_cnt !== 4'd15) begin
         failures++;
         $display("FAIL saturate lb=%0d done_at_end=%b cnt=%0d want lb=15 done_at_end=1 cnt=15",
                  lb_cnt, seen_done, b_pat_cnt);
      end
   endtask

   task automatic test_loopback_reset();
      logic [3:0] det_sh;
      int         lb_cnt;
      det_sh = 4'b0000; lb_cnt = 0;
      sel = 1'b1; repeat_n = 4'd4; start_b = 1'b1;
      step();
      start_b = 1'b0;
      for (int c = 0; c < 17; c++) begin
         if (b_out_valid === 1'b1) det_sh = {det_sh[2:0], b_out};
         if (b_last_bit === 1'b1) begin
            lb_cnt++;
            checks++;
            if (b_exp_code !== det_sh || b_exp_code !== 4'b1110) begin
               failures++;
               $display("FAIL loopback_code cyc%0d got=%b detector=%b want=1110", c, b_exp_code, det_sh);
            end
         end
         if (c == 16) begin
            checks++;
            if (b_done !== 1'b1 || lb_cnt != 4) begin
               failures++;
               $display("FAIL loopback_done done=%b lb=%0d want done=1 lb=4", b_done, lb_cnt);
            end
         end
         step();
      end
      sel = 1'b1; repeat_n = 4'd4; start_b = 1'b1;
      step();
      start_b = 1'b0;
      step(); step(); step();
      checks++;
      if (b_last_bit !== 1'b1 || b_pat_cnt !== 4'd1) begin
         failures++;
         $display("FAIL pre_reset lb=%b cnt=%0d want lb=1 cnt=1", b_last_bit, b_pat_cnt);
      end
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs_b() !== 9'd0 || b_pat_cnt !== 4'd0) begin
         failures++;
         $display("FAIL async_reset got=%b cnt=%0d want=%b cnt=0", obs_b(), b_pat_cnt, 9'd0);
      end
      step();
      rst_n = 1'b1;
      step();
      checks++;
      if (obs_b() !== 9'd0) begin
         failures++;
         $display("FAIL post_reset got=%b want=%b", obs_b(), 9'd0);
      end
   endtask

   initial begin
      test_reset();
      test_single_1001();
      test_repeat_gap();
      test_back_to_back();
      test_busy_start();
      test_abort();
      test_saturate();
      test_loopback_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seq_pattern_gen_1001_1110.md
Name: seq_pattern_gen_1001_1110

Overview:
Serial pattern transmitter that produces bit streams for the 1001/1110 Mealy sequence-detection path. On a start request it shifts out the 4-bit pattern 1001 or 1110, MSB first, one bit per clock. It repeats the pattern a programmable number of times, with optional idle gaps between repetitions. On each final bit it flags the 4-bit code the downstream detector is expected to report, so the pair can be checked in loopback.

Parameters:
CNT_W, 4, width of repeat count and pattern counter
GAP_CYCLES, 2, idle cycles (out=0, out_valid=0) between consecutive patterns; 0 = back-to-back; legal range 0..15

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; accepted only when busy=0
sel  input  1  pattern select: 0 -> 1001, 1 -> 1110; sampled on accepted start
repeat_n  input  CNT_W  number of patterns to send; 0 treated as 1; sampled on accepted start
abort  input  1  synchronous cancel of transmission in progress
out  output  1  serial data bit; 0 whenever out_valid=0
out_valid  output  1  out carries a pattern bit this cycle
busy  output  1  transmission in progress (SEND or GAP)
last_bit  output  1  high with bit0 of each pattern
exp_code  output  4  1001 or 1110 per latched sel while last_bit=1, else 0000
done  output  1  one-cycle pulse after final bit of final pattern
pat_cnt  output  CNT_W  patterns fully sent in current/last run; cleared on accepted start

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset: state=IDLE; out, out_valid, busy, last_bit, done=0; exp_code=0000; pat_cnt=0; latched sel/count=0.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - start=1 latches sel, repeat_n (0 -> 1), clears pat_cnt, loads bit index=3, enters SEND.
  - First bit is driven the cycle after start (latency 1).
- SEND:
  - Drives out = pattern[index], out_valid=1, busy=1; index decrements every cycle.
  - At index 0: last_bit=1, exp_code=pattern, pat_cnt increments that cycle.
  - After index 0, if patterns remain: go to GAP when GAP_CYCLES>0, else reload index=3 and stay in SEND (next pattern bit3 follows immediately).
  - After index 0 with no patterns remaining: go to DONE.
- GAP: out=0, out_valid=0, busy=1 for exactly GAP_CYCLES cycles, then SEND with index=3.
- DONE: done=1 for one cycle, busy=0, then IDLE. A start arriving in the DONE cycle is accepted (busy=0).
- start while busy=1 is ignored; no queuing. sel and repeat_n changes mid-run have no effect.
- abort=1 in SEND or GAP:
  - Next cycle: IDLE, out_valid=0, out=0, busy=0, last_bit=0, exp_code=0.
  - No done pulse; pat_cnt holds its value.
  - abort in IDLE/DONE has no effect; abort has priority over start in the same cycle.
- pat_cnt saturates at all-ones; repeat_n=all-ones sends 2^CNT_W-1 patterns.
- Async reset asserted mid-run returns to reset values immediately; no done pulse.

Test Plan:
- Reset, then start=1, sel=0, repeat_n=1 -> out_valid high 4 cycles starting 1 cycle after start; out=1,0,0,1; last_bit and exp_code=1001 on 4th bit; done pulse next cycle; pat_cnt=1.
- sel=1, repeat_n=3, GAP_CYCLES=2 -> 1110, 2 idle cycles, 1110, 2 idle, 1110; last_bit three times, each with exp_code=1110; done 1 cycle after last bit; pat_cnt=3; busy high 16 cycles.
- GAP_CYCLES=0, sel=0, repeat_n=2 -> contiguous stream 10011001, out_valid high 8 consecutive cycles.
- Busy-start and sel change: sel=0, repeat_n=2 running, pulse start with sel=1 on bit 2 -> ignored, output stays 10011001; repeat_n=0 -> exactly one pattern.
- Abort on 2nd bit of a sel=1 pattern -> next cycle out_valid=0, busy=0, no done, pat_cnt=0; new start one cycle later transmits normally.
- Loopback with detector: sel=1, repeat_n=4, GAP_CYCLES=0 -> exp_code on each last_bit matches detector output code; mid-run rst_n low -> all outputs 0 immediately.
